// File: rtl/decode_serializer_p_pkg.sv
// Shared types and RISC-V field offsets for the serializing decode stage.
package decode_serializer_p_pkg;

  typedef enum logic [1:0] {
    OP_SEL_IMM   = 2'd0,
    OP_SEL_REG   = 2'd1,
    OP_SEL_PC    = 2'd2,
    OP_SEL_ADDER = 2'd3
  } op_sel_e;

  typedef enum logic {
    ADD_SEL_REG = 1'b0,
    ADD_SEL_PC  = 1'b1
  } add_sel_e;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_BUSY = 1'b1
  } ser_state_e;

  localparam int REG_FIELD_W = 5;
  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;

  // Beat index width; a single-beat operand still carries a 1-bit index.
  function automatic int idx_width(input int nbeats);
    if (nbeats > 1) begin
      return $clog2(nbeats);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/decode_serializer_p_if.sv
// Beat stream from the decode serializer to the narrow execute datapath.
interface decode_serializer_p_if #(
  parameter int DATA_W = 32,
  parameter int DP_W   = 16
) ();
  import decode_serializer_p_pkg::*;

  localparam int NBEATS = DATA_W / DP_W;
  localparam int IDX_W  = idx_width(NBEATS);

  logic              out_valid;
  logic              out_ready;
  logic [DP_W-1:0]   beat;
  logic [IDX_W-1:0]  beat_idx;
  logic              first_beat;
  logic              last_beat;

  modport master (
    output out_valid, beat, beat_idx, first_beat, last_beat,
    input  out_ready
  );

  modport slave (
    input  out_valid, beat, beat_idx, first_beat, last_beat,
    output out_ready
  );

endinterface

// File: rtl/decode_serializer_p_slice_mux.sv
// Combinational beat-counter/order to operand-slice selector (module slice_mux_p).
module slice_mux_p
  import decode_serializer_p_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DP_W   = 16
) (
  input  logic [DATA_W-1:0]                 data,
  input  logic [idx_width(DATA_W/DP_W)-1:0] cnt,
  input  logic                              msb_first,
  output logic [DP_W-1:0]                   slice,
  output logic [idx_width(DATA_W/DP_W)-1:0] idx
);

  localparam int NBEATS = DATA_W / DP_W;
  localparam int IDX_W  = idx_width(NBEATS);

  logic [IDX_W-1:0] idx_s;

  // Map transfer position to slice index according to beat order
  always_comb begin
    idx_s = cnt;
    if (msb_first) begin
      idx_s = IDX_W'(NBEATS - 1) - cnt;
    end else begin
      idx_s = cnt;
    end
  end

  assign idx   = idx_s;
  assign slice = DP_W'(data >> (int'(idx_s) * DP_W));

endmodule

// File: rtl/decode_serializer_p.sv
// Serializing decode stage: latches one instruction's operand/address, streams DP_W beats.
// Optional macro DEC_SER_BACK2BACK_EN allows a new capture on the last beat (no bubble).
module decode_serializer_p
  import decode_serializer_p_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DP_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [DATA_W-1:0]      pc_i,
  input  logic [DATA_W-1:0]      reg1_i,
  input  logic [DATA_W-1:0]      imm_i,
  input  logic [1:0]             op_sel_i,
  input  logic                   add_sel_i,
  input  logic                   msb_first_i,
  input  logic                   hazard_i,
  decode_serializer_p_if.master  out_if,
  output logic [DATA_W-1:0]      addr_o,
  output logic [4:0]             rd_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o
);

  localparam int NBEATS = DATA_W / DP_W;
  localparam int IDX_W  = idx_width(NBEATS);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NBEATS - 1);

  if ((DATA_W % DP_W) != 0) begin : g_width_err
    $error("DATA_W must be a multiple of DP_W");
  end
  if ((NBEATS < 1) || (NBEATS > 32)) begin : g_nbeats_err
    $error("DATA_W/DP_W must lie in 1..32");
  end

  ser_state_e                state_r, state_s;
  logic [IDX_W-1:0]          cnt_r, cnt_s;
  logic [DATA_W-1:0]         operand_r, addr_r;
  logic [REG_FIELD_W-1:0]    rd_r, rs1_r, rs2_r;
  logic                      msb_r;

  logic [DATA_W-1:0]         sum_s, operand_s;
  logic                      busy_s, valid_s, last_s, advance_s, ready_s, capture_s;
  logic [DP_W-1:0]           slice_s;
  logic [IDX_W-1:0]          idx_s;
  logic                      unused_inst_s;

  assign unused_inst_s = ^{inst_i[RD_LSB-1:0], inst_i[RS1_LSB-1:RD_LSB+REG_FIELD_W],
                           inst_i[31:RS2_LSB+REG_FIELD_W]};

  // Address adder and operand source selection
  always_comb begin
    sum_s     = reg1_i + imm_i;
    operand_s = imm_i;
    if (add_sel_e'(add_sel_i) == ADD_SEL_PC) begin
      sum_s = pc_i + imm_i;
    end else begin
      sum_s = reg1_i + imm_i;
    end
    case (op_sel_e'(op_sel_i))
      OP_SEL_IMM:   operand_s = imm_i;
      OP_SEL_REG:   operand_s = reg1_i;
      OP_SEL_PC:    operand_s = pc_i;
      OP_SEL_ADDER: operand_s = sum_s;
      default:      operand_s = imm_i;
    endcase
  end

  // Handshake qualifiers for both channels
  always_comb begin
    busy_s    = (state_r == SER_BUSY);
    valid_s   = busy_s && !hazard_i;
    last_s    = (cnt_r == LAST_CNT);
    advance_s = valid_s && out_if.out_ready;
    ready_s   = 1'b0;
    if (!busy_s) begin
      ready_s = 1'b1;
    end else begin
`ifdef DEC_SER_BACK2BACK_EN
      ready_s = last_s && advance_s;
`else
      ready_s = 1'b0;
`endif
    end
    capture_s = in_valid_i && ready_s && !hazard_i;
  end

  // Next-state and beat counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      SER_IDLE: begin
        if (capture_s) begin
          state_s = SER_BUSY;
          cnt_s   = {IDX_W{1'b0}};
        end else begin
          state_s = SER_IDLE;
          cnt_s   = cnt_r;
        end
      end
      SER_BUSY: begin
        if (advance_s && !last_s) begin
          cnt_s = cnt_r + IDX_W'(1);
        end else if (advance_s && capture_s) begin
          state_s = SER_BUSY;
          cnt_s   = {IDX_W{1'b0}};
        end else if (advance_s) begin
          state_s = SER_IDLE;
          cnt_s   = {IDX_W{1'b0}};
        end else begin
          state_s = SER_BUSY;
          cnt_s   = cnt_r;
        end
      end
      default: begin
        state_s = SER_IDLE;
        cnt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, counter and latched instruction data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= SER_IDLE;
      cnt_r     <= {IDX_W{1'b0}};
      operand_r <= {DATA_W{1'b0}};
      addr_r    <= {DATA_W{1'b0}};
      rd_r      <= {REG_FIELD_W{1'b0}};
      rs1_r     <= {REG_FIELD_W{1'b0}};
      rs2_r     <= {REG_FIELD_W{1'b0}};
      msb_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        operand_r <= operand_s;
        addr_r    <= sum_s;
        rd_r      <= inst_i[RD_LSB  +: REG_FIELD_W];
        rs1_r     <= inst_i[RS1_LSB +: REG_FIELD_W];
        rs2_r     <= inst_i[RS2_LSB +: REG_FIELD_W];
        msb_r     <= msb_first_i;
      end
    end
  end

  slice_mux_p #(.DATA_W(DATA_W), .DP_W(DP_W)) u_slice_mux (
    .data      (operand_r),
    .cnt       (cnt_r),
    .msb_first (msb_r),
    .slice     (slice_s),
    .idx       (idx_s)
  );

  // Everything is forced quiet while reset is held
  assign in_ready_o        = ready_s && !rst;
  assign out_if.out_valid  = valid_s && !rst;
  assign out_if.beat       = rst ? {DP_W{1'b0}} : slice_s;
  assign out_if.beat_idx   = rst ? {IDX_W{1'b0}} : idx_s;
  assign out_if.first_beat = valid_s && !rst && (cnt_r == {IDX_W{1'b0}});
  assign out_if.last_beat  = valid_s && !rst && last_s;
  assign addr_o            = rst ? {DATA_W{1'b0}} : addr_r;
  assign rd_o              = rst ? {REG_FIELD_W{1'b0}} : rd_r;
  assign rs1_o             = rst ? {REG_FIELD_W{1'b0}} : rs1_r;
  assign rs2_o             = rst ? {REG_FIELD_W{1'b0}} : rs2_r;

endmodule

// File: doc/decode_serializer_p.md
Name: decode_serializer_p

Overview:
- Parametrised successor to the core's serializing decode stage.
- Captures one decoded instruction's operand set and computes a 32-bit address/jump target once.
- Streams the selected 32-bit operand to the narrow execute datapath as DATA_W/DP_W beats under valid/ready, honouring per-transaction beat order and a downstream hazard stall.
- Sits between the control/immediate-generation logic and the execute stage.

Parameters:
- DATA_W, 32: operand and address width.
- DP_W, 16: execute datapath slice width. DATA_W % DP_W must be 0; elaboration error otherwise.
- NBEATS, DATA_W/DP_W: derived, not overridable. Legal range 1..32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  decoded instruction available.
- in_ready_o  out  1  block accepts an instruction this cycle.
- inst_i  in  32  raw instruction; rd=[11:7], rs1=[19:15], rs2=[24:20].
- pc_i  in  DATA_W  instruction PC.
- reg1_i  in  DATA_W  rs1 read data.
- imm_i  in  DATA_W  sign-extended immediate from the immediate generator.
- op_sel_i  in  2  operand source: 0=IMM, 1=REG, 2=PC, 3=ADDER.
- add_sel_i  in  1  adder A input: 0=reg1_i, 1=pc_i. Adder B is always imm_i.
- msb_first_i  in  1  beat order for this transaction.
- hazard_i  in  1  downstream hazard stall.
- out_valid_o  out  1  beat_o valid.
- out_ready_i  in  1  execute stage consumes the beat.
- beat_o  out  DP_W  current operand slice.
- beat_idx_o  out  max(1,$clog2(NBEATS))  slice index within the operand, 0 = least significant.
- first_beat_o  out  1  first beat of the transaction.
- last_beat_o  out  1  last beat of the transaction.
- addr_o  out  DATA_W  latched adder result (LSU address / jump target).
- rd_o, rs1_o, rs2_o  out  5  latched register fields.

Behaviour:
- States: IDLE, BUSY. Reset state is IDLE.
- While rst=1:
  - At each edge: state←IDLE, beat counter←0, all data registers←0.
  - Outputs: in_ready_o=0, out_valid_o=0, beat_o=0, addr_o=0, rd/rs1/rs2=0, flags=0.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - Capture occurs on in_valid_i && !hazard_i. It latches:
    - the operand selected by op_sel_i;
    - addr_o = (add_sel_i ? pc_i : reg1_i) + imm_i, modulo 2^DATA_W with no carry-out;
    - rd_o, rs1_o, rs2_o and msb_first_i.
  - After capture: counter←0, go to BUSY.
  - in_valid_i while hazard_i=1 is not accepted, and nothing is latched.
- BUSY:
  - in_ready_o=0 (see Optional Feature), out_valid_o=!hazard_i.
  - Slice index: beat_idx = msb_first ? NBEATS-1-counter : counter.
  - beat_o = operand[beat_idx*DP_W +: DP_W].
  - first_beat_o = (counter==0); last_beat_o = (counter==NBEATS-1). Both are qualified by out_valid_o.
  - Advance on out_valid_o && out_ready_i:
    - not last: counter+1;
    - last: counter←0, go to IDLE.
  - hazard_i=1 freezes counter, state and all latched data; out_valid_o=0.
- Latency: capture at edge t; first beat visible in cycle t+1; a transaction takes at least NBEATS cycles in BUSY.
- Without the optional feature, there is one IDLE bubble between transactions.
- NBEATS=1: first and last are asserted together; each transaction takes one BUSY cycle.
- addr_o, rd_o, rs1_o and rs2_o hold until the next capture. They stay stable for the whole transaction.
- Reset in mid-transfer aborts the transaction. No partial beat is emitted after the reset edge.

Optional Feature:
- Macro DEC_SER_BACK2BACK_EN.
- Defined:
  - In BUSY, in_ready_o = last_beat_o && out_valid_o && out_ready_i.
  - A capture in that cycle reloads all registers, sets counter←0 and stays in BUSY.
  - Result: zero bubbles; sustained throughput is one beat per cycle.
- Undefined: behaviour as above. in_ready_o is never asserted in BUSY.

Decomposition:
- Shared package typedefs gets:
  - op_sel_e (OP_SEL_IMM/REG/PC/ADDER);
  - add_sel_e (ADD_SEL_REG/PC);
  - ser_state_e (SER_IDLE/SER_BUSY).
- RISC-V field-offset constants also go in the package.
- One natural sub-module: slice_mux_p (DATA_W, DP_W). It is a combinational index/order-to-slice selector and is reusable by the execute stage's deserializer.

Test Plan:
- DP_W=16, op_sel=REG, reg1=0xDEADBEEF, msb_first=0 -> beats 0xBEEF (idx0, first), 0xDEAD (idx1, last), then IDLE.
- Same with msb_first=1 -> 0xDEAD (idx1, first), 0xBEEF (idx0, last).
- DP_W=8, op_sel=ADDER, add_sel=PC, pc=0x00001000, imm=0xFFFFFFFC -> addr_o=0x00000FFC; beats 0xFC, 0x0F, 0x00, 0x00.
- DP_W=16, hazard_i=1 for 3 cycles after the first beat -> out_valid_o=0 for those cycles, beat_idx stays 1, and 0xDEAD is emitted after the release.
- Two queued instructions, out_ready_i=1 constantly -> one bubble between transactions without the macro, none with DEC_SER_BACK2BACK_EN.
- rst pulsed during beat 0 of 2 -> the next cycle shows out_valid_o=0 and addr_o=0, and the next capture begins cleanly at idx0.
